id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the 8-bit, 8-register pipelined core. It captures the operands read from the register file together with the decoded control of the instruction in ID and presents them to EX one cycle later. It detects load-use hazards and inserts a bubble, stalling IF/ID for that cycle. It also honours a branch flush from EX and a whole-pipe hold from a busy memory stage, refreshing held operands from writeback while held.

## Interface
Parameters:
- none; data width 8, register index width 3 (fixed by the register file).

Ports:
- clock  in  1  single clock; all state updates on rising edge
- resetN  in  1  synchronous, active-low reset
- idValid  in  1  ID holds a real instruction
- idRs1, idRs2  in  3 each  source register indices (same values drive the register-file read addresses)
- idUsesRs2  in  1  instruction reads Rs2 (R-type/store)
- idRd  in  3  destination register index
- idReadData1, idReadData2  in  8 each  register-file read data
- idImm  in  8  sign-extended immediate
- idRegWrite, idMemRead, idMemWrite, idAluSrc  in  1 each  decoded control
- idAluOp  in  3  ALU operation
- flush  in  1  branch taken in EX; kill the instruction in ID
- memBusy  in  1  MEM stage busy; entire front of pipe holds
- wbRegWrite  in  1; wbRd  in  3; wbData  in  8  writeback port (mirrors the register-file write)
- stallIfId  out  1  freeze PC and IF/ID this cycle (combinational)
- exValid  out  1; exRs1, exRs2, exRd  out  3 each
- exA, exB, exImm  out  8 each
- exRegWrite, exMemRead, exMemWrite, exAluSrc  out  1 each; exAluOp  out  3

## Operation
- hazard = idValid & exValid & exMemRead & (exRd != 0) & ((exRd == idRs1) | (idUsesRs2 & (exRd == idRs2))).
- stallIfId = memBusy | (hazard & ~flush).
- Per rising edge, first matching action wins:
  1. resetN == 0: every ex* output cleared to 0.
  2. memBusy == 1 (HOLD): all ex* registers keep their values, except operand refresh: if wbRegWrite & wbRd != 0 & wbRd == exRs1 then exA <= wbData; likewise exB when wbRd == exRs2. flush is ignored during HOLD; the source keeps it asserted until memBusy drops.
  3. flush == 1 (BUBBLE): exValid and all ex control bits <= 0, and every data/index field <= 0.
  4. hazard == 1 (BUBBLE): same as 3; the ID instruction is kept in IF/ID by stallIfId and re-captured next cycle.
  5. otherwise (LOAD): ex* <= id* (exValid <= idValid). If idValid == 0, the control bits are loaded as 0 regardless of the id* control inputs.
- Register 0 never causes a hazard and is never refreshed.
- A bubble is architecturally a no-op: exRegWrite = exMemRead = exMemWrite = 0.
- No forwarding muxes live here. EX/MEM and MEM/WB forwarding belong to EX. The register file writes on both edges, so a same-cycle WB write is already visible on idReadData*.

## Timing
- Latency ID to EX: 1 cycle. A load-use pair costs exactly 1 bubble cycle.
- stallIfId is combinational from memBusy, flush, the id* inputs and the ex* state. It has no reset value of its own: it is 0 after reset unless memBusy = 1.
- Reset values: all ex* outputs = 0 (exValid = 0).
- Reset asserted during HOLD or a stall: state clears on that edge. The instruction in IF/ID is discarded upstream by the same reset.
- flush and hazard in the same cycle: flush wins; stallIfId = 0 so the fetch redirect proceeds.
- memBusy and hazard in the same cycle: HOLD. The hazard is re-evaluated after memBusy drops.
- Refresh and a new load on the same edge cannot occur: refresh happens only in HOLD.

## Test plan
- Reset: set resetN = 0 with all id* inputs nonzero for 1 edge -> all ex* = 0. With memBusy = 0, stallIfId = 0.
- Pass-through: idValid = 1, Rs1 = 2, Rs2 = 3, Rd = 4, data 0x11/0x22, imm 0xF0, AluOp = 5, RegWrite = 1 -> next cycle the ex* fields hold exactly these values, and stallIfId stays 0.
- Load-use: EX holds a load (MemRead = 1) with Rd = 3, and ID has Rs2 = 3 with UsesRs2 = 1 -> stallIfId = 1 for 1 cycle and exValid = 0 after the edge. The following edge loads the ID instruction. Repeat with Rd = 0 -> no stall.
- Flush: flush = 1 while a hazard is present -> stallIfId = 0, next exValid = 0, exRegWrite = 0.
- Hold + refresh: memBusy = 1 for 3 cycles with exRs1 = 5, exA = 0x07, and WB writes r5 = 0xAB in cycle 2 -> ex* unchanged except exA = 0xAB, and stallIfId = 1 throughout. A write to r0 changes nothing.
- Reset mid-hold: memBusy = 1 and resetN = 0 on one edge -> ex* = 0 while stallIfId remains 1.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundles the ID-side inputs, the control inputs (flush, hold,
// writeback) and the EX-side outputs of the ID/EX pipeline stage.
//   master : the surrounding pipeline. It drives id*, flush, memBusy and wb*,
//            and it reads stallIfId and ex*.
//   slave  : the ID/EX stage itself.
interface id_ex_stage_if;
  localparam int unsigned DataW  = 8;
  localparam int unsigned RegW   = 3;
  localparam int unsigned AluOpW = 3;

  // ID side
  logic              idValid;
  logic [RegW-1:0]   idRs1;
  logic [RegW-1:0]   idRs2;
  logic              idUsesRs2;
  logic [RegW-1:0]   idRd;
  logic [DataW-1:0]  idReadData1;
  logic [DataW-1:0]  idReadData2;
  logic [DataW-1:0]  idImm;
  logic              idRegWrite;
  logic              idMemRead;
  logic              idMemWrite;
  logic              idAluSrc;
  logic [AluOpW-1:0] idAluOp;

  // Pipeline control and writeback
  logic              flush;
  logic              memBusy;
  logic              wbRegWrite;
  logic [RegW-1:0]   wbRd;
  logic [DataW-1:0]  wbData;

  // EX side
  logic              stallIfId;
  logic              exValid;
  logic [RegW-1:0]   exRs1;
  logic [RegW-1:0]   exRs2;
  logic [RegW-1:0]   exRd;
  logic [DataW-1:0]  exA;
  logic [DataW-1:0]  exB;
  logic [DataW-1:0]  exImm;
  logic              exRegWrite;
  logic              exMemRead;
  logic              exMemWrite;
  logic              exAluSrc;
  logic [AluOpW-1:0] exAluOp;

  modport master (
    output idValid, idRs1, idRs2, idUsesRs2, idRd, idReadData1, idReadData2,
           idImm, idRegWrite, idMemRead, idMemWrite, idAluSrc, idAluOp,
           flush, memBusy, wbRegWrite, wbRd, wbData,
    input  stallIfId, exValid, exRs1, exRs2, exRd, exA, exB, exImm,
           exRegWrite, exMemRead, exMemWrite, exAluSrc, exAluOp
  );

  modport slave (
    input  idValid, idRs1, idRs2, idUsesRs2, idRd, idReadData1, idReadData2,
           idImm, idRegWrite, idMemRead, idMemWrite, idAluSrc, idAluOp,
           flush, memBusy, wbRegWrite, wbRd, wbData,
    output stallIfId, exValid, exRs1, exRs2, exRd, exA, exB, exImm,
           exRegWrite, exMemRead, exMemWrite, exAluSrc, exAluOp
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: the ID/EX pipeline register of the 8-bit, 8-register core.
// It captures the operands and decoded control from ID and presents them to
// EX one cycle later. It inserts a bubble on a load-use hazard and raises
// stallIfId for that cycle. It turns the ID instruction into a bubble on a
// branch flush. It holds everything while MEM is busy; during that hold the
// held operands are refreshed from the writeback port.
// Ports:
//   clock  : rising-edge clock
//   resetN : synchronous, active-low reset (clears every ex* field)
//   bus    : id_ex_stage_if.slave
//            inputs  : id*, flush, memBusy, wb*
//            outputs : ex* (registered), stallIfId (combinational)
module id_ex_stage (
  input  logic         clock,
  input  logic         resetN,
  id_ex_stage_if.slave bus
);
  localparam int unsigned DataW  = 8;
  localparam int unsigned RegW   = 3;
  localparam int unsigned AluOpW = 3;

  typedef struct packed {
    logic              valid;
    logic [RegW-1:0]   rs1;
    logic [RegW-1:0]   rs2;
    logic [RegW-1:0]   rd;
    logic [DataW-1:0]  a;
    logic [DataW-1:0]  b;
    logic [DataW-1:0]  imm;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic              aluSrc;
    logic [AluOpW-1:0] aluOp;
  } exRegs_t;

  exRegs_t exQ;
  exRegs_t exD;
  logic    hazard;
  logic    wbHit;

  // Load-use detection: a load in EX whose destination the ID instruction reads.
  // Register 0 is hard-wired, so it never causes a hazard.
  always_comb begin : hazardDetect
    hazard = bus.idValid & exQ.valid & exQ.memRead & (exQ.rd != RegW'(0)) &
             ((exQ.rd == bus.idRs1) | (bus.idUsesRs2 & (exQ.rd == bus.idRs2)));
    // A flush redirects fetch, so it overrides the hazard stall. A hold always stalls.
    bus.stallIfId = bus.memBusy | (hazard & ~bus.flush);
  end

  // Writeback to a non-zero register; the hold refresh uses it.
  assign wbHit = bus.wbRegWrite & (bus.wbRd != RegW'(0));

  // Next-state selection in priority order: hold, bubble, load.
  always_comb begin : nextState
    exD = exQ;
    if (bus.memBusy) begin
      // Hold. Flush is ignored here; its source keeps it asserted until the hold ends.
      if (wbHit && (bus.wbRd == exQ.rs1)) begin
        exD.a = bus.wbData;
      end
      if (wbHit && (bus.wbRd == exQ.rs2)) begin
        exD.b = bus.wbData;
      end
    end else if (bus.flush || hazard) begin
      // Bubble: every field cleared, so no architectural side effects.
      exD = '0;
    end else begin
      exD.valid    = bus.idValid;
      exD.rs1      = bus.idRs1;
      exD.rs2      = bus.idRs2;
      exD.rd       = bus.idRd;
      exD.a        = bus.idReadData1;
      exD.b        = bus.idReadData2;
      exD.imm      = bus.idImm;
      exD.aluOp    = bus.idAluOp;
      // Side-effect controls are gated by idValid.
      exD.regWrite = bus.idValid & bus.idRegWrite;
      exD.memRead  = bus.idValid & bus.idMemRead;
      exD.memWrite = bus.idValid & bus.idMemWrite;
      exD.aluSrc   = bus.idValid & bus.idAluSrc;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clock) begin : exReg
    if (!resetN) begin
      exQ <= '0;
    end else begin
      exQ <= exD;
    end
  end

  assign bus.exValid    = exQ.valid;
  assign bus.exRs1      = exQ.rs1;
  assign bus.exRs2      = exQ.rs2;
  assign bus.exRd       = exQ.rd;
  assign bus.exA        = exQ.a;
  assign bus.exB        = exQ.b;
  assign bus.exImm      = exQ.imm;
  assign bus.exRegWrite = exQ.regWrite;
  assign bus.exMemRead  = exQ.memRead;
  assign bus.exMemWrite = exQ.memWrite;
  assign bus.exAluSrc   = exQ.aluSrc;
  assign bus.exAluOp    = exQ.aluOp;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: bench for id_ex_stage. It applies a table of directed
// vectors and then a random phase that is compared against a reference
// model of the pipeline-stage rules.
module tb_id_ex_stage;
  typedef struct packed {
    logic       valid;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] imm;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       aluSrc;
    logic [2:0] aluOp;
  } ex_t;

  typedef struct packed {
    logic       resetN;
    logic       idValid;
    logic [2:0] idRs1;
    logic [2:0] idRs2;
    logic       idUsesRs2;
    logic [2:0] idRd;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] imm;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       aluSrc;
    logic [2:0] aluOp;
    logic       flush;
    logic       memBusy;
    logic       wbRegWrite;
    logic [2:0] wbRd;
    logic [7:0] wbData;
  } stim_t;

  typedef struct {
    stim_t s;
    logic  chkStall;
    logic  expStall;
    ex_t   exp;
  } vec_t;

  localparam int unsigned NumVec  = 18;
  localparam int unsigned NumRand = 400;

  logic clock;
  logic resetN;
  int   tests;
  int   fails;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    s.resetN = 1'b1;
    return s;
  endfunction

  function automatic stim_t mkId(logic v, logic [2:0] rs1, logic [2:0] rs2, logic uses,
                                 logic [2:0] rd, logic [7:0] d1, logic [7:0] d2,
                                 logic [7:0] imm, logic rw, logic mr, logic mw,
                                 logic as, logic [2:0] op);
    stim_t s;
    s = idleStim();
    s.idValid = v;  s.idRs1 = rs1; s.idRs2 = rs2; s.idUsesRs2 = uses; s.idRd = rd;
    s.d1 = d1; s.d2 = d2; s.imm = imm;
    s.regWrite = rw; s.memRead = mr; s.memWrite = mw; s.aluSrc = as; s.aluOp = op;
    return s;
  endfunction

  function automatic ex_t mkEx(logic v, logic [2:0] rs1, logic [2:0] rs2, logic [2:0] rd,
                               logic [7:0] a, logic [7:0] b, logic [7:0] imm,
                               logic rw, logic mr, logic mw, logic as, logic [2:0] op);
    ex_t e;
    e.valid = v; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.a = a; e.b = b; e.imm = imm;
    e.regWrite = rw; e.memRead = mr; e.memWrite = mw; e.aluSrc = as; e.aluOp = op;
    return e;
  endfunction

  // Reference model: the stage's rules applied to an abstract EX record.
  function automatic logic modelHazard(ex_t cur, stim_t s);
    if (!(s.idValid && cur.valid && cur.memRead) || cur.rd == 3'd0) return 1'b0;
    if (cur.rd == s.idRs1) return 1'b1;
    return s.idUsesRs2 && (cur.rd == s.idRs2);
  endfunction

  function automatic logic modelStall(ex_t cur, stim_t s);
    if (s.memBusy) return 1'b1;
    if (s.flush) return 1'b0;
    return modelHazard(cur, s);
  endfunction

  function automatic ex_t modelNext(ex_t cur, stim_t s);
    ex_t n;
    if (!s.resetN) return '0;
    if (s.memBusy) begin
      n = cur;
      if (s.wbRegWrite && s.wbRd != 3'd0 && s.wbRd == cur.rs1) n.a = s.wbData;
      if (s.wbRegWrite && s.wbRd != 3'd0 && s.wbRd == cur.rs2) n.b = s.wbData;
      return n;
    end
    if (s.flush || modelHazard(cur, s)) return '0;
    if (s.idValid)
      return mkEx(1'b1, s.idRs1, s.idRs2, s.idRd, s.d1, s.d2, s.imm,
                  s.regWrite, s.memRead, s.memWrite, s.aluSrc, s.aluOp);
    return mkEx(1'b0, s.idRs1, s.idRs2, s.idRd, s.d1, s.d2, s.imm,
                1'b0, 1'b0, 1'b0, 1'b0, s.aluOp);
  endfunction

  task automatic applyStim(input stim_t s);
    resetN          = s.resetN;
    bus.idValid     = s.idValid;
    bus.idRs1       = s.idRs1;
    bus.idRs2       = s.idRs2;
    bus.idUsesRs2   = s.idUsesRs2;
    bus.idRd        = s.idRd;
    bus.idReadData1 = s.d1;
    bus.idReadData2 = s.d2;
    bus.idImm       = s.imm;
    bus.idRegWrite  = s.regWrite;
    bus.idMemRead   = s.memRead;
    bus.idMemWrite  = s.memWrite;
    bus.idAluSrc    = s.aluSrc;
    bus.idAluOp     = s.aluOp;
    bus.flush       = s.flush;
    bus.memBusy     = s.memBusy;
    bus.wbRegWrite  = s.wbRegWrite;
    bus.wbRd        = s.wbRd;
    bus.wbData      = s.wbData;
  endtask

  function automatic ex_t readEx();
    return mkEx(bus.exValid, bus.exRs1, bus.exRs2, bus.exRd, bus.exA, bus.exB, bus.exImm,
                bus.exRegWrite, bus.exMemRead, bus.exMemWrite, bus.exAluSrc, bus.exAluOp);
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  vec_t vecs [NumVec];
  stim_t rs;
  ex_t   mdl;

  initial begin
    tests = 0;
    fails = 0;
    applyStim(idleStim());

    // Reset with every ID input nonzero. The first stall is not checked
    // because the EX state is unknown before the first reset.
    vecs[0].s = mkId(1, 3'd1, 3'd2, 1, 3'd3, 8'hA1, 8'hA2, 8'hA3, 1, 1, 1, 1, 3'd7);
    vecs[0].s.resetN = 1'b0;
    vecs[0].chkStall = 0; vecs[0].expStall = 0; vecs[0].exp = '0;
    vecs[1] = vecs[0]; vecs[1].chkStall = 1;
    // Pass-through
    vecs[2].s = mkId(1, 3'd2, 3'd3, 1, 3'd4, 8'h11, 8'h22, 8'hF0, 1, 0, 0, 0, 3'd5);
    vecs[2].chkStall = 1; vecs[2].expStall = 0;
    vecs[2].exp = mkEx(1, 3'd2, 3'd3, 3'd4, 8'h11, 8'h22, 8'hF0, 1, 0, 0, 0, 3'd5);
    // Load into r3, then a user of r3 via Rs2: one bubble, then the user loads
    vecs[3].s = mkId(1, 3'd1, 3'd2, 0, 3'd3, 8'h30, 8'h40, 8'h04, 1, 1, 0, 1, 3'd0);
    vecs[3].chkStall = 1; vecs[3].expStall = 0;
    vecs[3].exp = mkEx(1, 3'd1, 3'd2, 3'd3, 8'h30, 8'h40, 8'h04, 1, 1, 0, 1, 3'd0);
    vecs[4].s = mkId(1, 3'd6, 3'd3, 1, 3'd7, 8'h55, 8'h66, 8'h00, 1, 0, 0, 0, 3'd1);
    vecs[4].chkStall = 1; vecs[4].expStall = 1; vecs[4].exp = '0;
    vecs[5].s = mkId(1, 3'd6, 3'd3, 1, 3'd7, 8'h55, 8'h99, 8'h00, 1, 0, 0, 0, 3'd1);
    vecs[5].chkStall = 1; vecs[5].expStall = 0;
    vecs[5].exp = mkEx(1, 3'd6, 3'd3, 3'd7, 8'h55, 8'h99, 8'h00, 1, 0, 0, 0, 3'd1);
    // Load into r0 followed by a reader of r0: no stall
    vecs[6].s = mkId(1, 3'd1, 3'd2, 0, 3'd0, 8'h01, 8'h02, 8'h08, 1, 1, 0, 1, 3'd0);
    vecs[6].chkStall = 1; vecs[6].expStall = 0;
    vecs[6].exp = mkEx(1, 3'd1, 3'd2, 3'd0, 8'h01, 8'h02, 8'h08, 1, 1, 0, 1, 3'd0);
    vecs[7].s = mkId(1, 3'd0, 3'd0, 1, 3'd5, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 3'd2);
    vecs[7].chkStall = 1; vecs[7].expStall = 0;
    vecs[7].exp = mkEx(1, 3'd0, 3'd0, 3'd5, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 3'd2);
    // Load into r4, then a hazard with flush asserted: the flush wins
    vecs[8].s = mkId(1, 3'd2, 3'd1, 0, 3'd4, 8'h0A, 8'h0B, 8'h10, 1, 1, 0, 1, 3'd0);
    vecs[8].chkStall = 1; vecs[8].expStall = 0;
    vecs[8].exp = mkEx(1, 3'd2, 3'd1, 3'd4, 8'h0A, 8'h0B, 8'h10, 1, 1, 0, 1, 3'd0);
    vecs[9].s = mkId(1, 3'd4, 3'd0, 0, 3'd6, 8'h12, 8'h34, 8'h00, 1, 0, 0, 0, 3'd3);
    vecs[9].s.flush = 1'b1;
    vecs[9].chkStall = 1; vecs[9].expStall = 0; vecs[9].exp = '0;
    // Hold with refresh. EX holds rs1=5, a=0x07, rs2=6.
    vecs[10].s = mkId(1, 3'd5, 3'd6, 1, 3'd1, 8'h07, 8'h08, 8'h21, 1, 0, 0, 0, 3'd4);
    vecs[10].chkStall = 1; vecs[10].expStall = 0;
    vecs[10].exp = mkEx(1, 3'd5, 3'd6, 3'd1, 8'h07, 8'h08, 8'h21, 1, 0, 0, 0, 3'd4);
    vecs[11].s = mkId(1, 3'd3, 3'd2, 1, 3'd2, 8'hEE, 8'hEF, 8'h77, 1, 1, 1, 1, 3'd6);
    vecs[11].s.memBusy = 1'b1;
    vecs[11].chkStall = 1; vecs[11].expStall = 1; vecs[11].exp = vecs[10].exp;
    vecs[12].s = vecs[11].s;
    vecs[12].s.wbRegWrite = 1'b1; vecs[12].s.wbRd = 3'd5; vecs[12].s.wbData = 8'hAB;
    vecs[12].chkStall = 1; vecs[12].expStall = 1;
    vecs[12].exp = mkEx(1, 3'd5, 3'd6, 3'd1, 8'hAB, 8'h08, 8'h21, 1, 0, 0, 0, 3'd4);
    // A write to r0 changes nothing, and a flush during the hold is ignored
    vecs[13].s = vecs[11].s; vecs[13].s.flush = 1'b1;
    vecs[13].s.wbRegWrite = 1'b1; vecs[13].s.wbRd = 3'd0; vecs[13].s.wbData = 8'hCC;
    vecs[13].chkStall = 1; vecs[13].expStall = 1; vecs[13].exp = vecs[12].exp;
    vecs[14].s = vecs[11].s;
    vecs[14].s.wbRegWrite = 1'b1; vecs[14].s.wbRd = 3'd6; vecs[14].s.wbData = 8'h5A;
    vecs[14].chkStall = 1; vecs[14].expStall = 1;
    vecs[14].exp = mkEx(1, 3'd5, 3'd6, 3'd1, 8'hAB, 8'h5A, 8'h21, 1, 0, 0, 0, 3'd4);
    // Reset during the hold
    vecs[15].s = vecs[11].s; vecs[15].s.resetN = 1'b0;
    vecs[15].chkStall = 1; vecs[15].expStall = 1; vecs[15].exp = '0;
    vecs[16].s = idleStim();
    vecs[16].chkStall = 1; vecs[16].expStall = 0; vecs[16].exp = '0;
    // A non-valid ID instruction loads with its control bits forced to 0
    vecs[17].s = mkId(0, 3'd1, 3'd2, 1, 3'd3, 8'h44, 8'h45, 8'h46, 1, 1, 1, 1, 3'd0);
    vecs[17].chkStall = 1; vecs[17].expStall = 0;
    vecs[17].exp = mkEx(0, 3'd1, 3'd2, 3'd3, 8'h44, 8'h45, 8'h46, 0, 0, 0, 0, 3'd0);

    for (int i = 0; i < int'(NumVec); i++) begin
      @(negedge clock);
      applyStim(vecs[i].s);
      #1;
      if (vecs[i].chkStall)
        check("vecStall", i, 64'(bus.stallIfId), 64'(vecs[i].expStall));
      @(posedge clock);
      #1;
      check("vecEx", i, 64'(readEx()), 64'(vecs[i].exp));
    end

    // Random phase. Register indices are kept small so that hazards occur often.
    mdl = vecs[NumVec-1].exp;
    for (int i = 0; i < int'(NumRand); i++) begin
      rs = idleStim();
      rs.resetN     = ($urandom_range(0, 29) != 0);
      rs.idValid    = ($urandom_range(0, 4) != 0);
      rs.idRs1      = 3'($urandom_range(0, 3));
      rs.idRs2      = 3'($urandom_range(0, 3));
      rs.idUsesRs2  = 1'($urandom);
      rs.idRd       = 3'($urandom_range(0, 3));
      rs.d1         = 8'($urandom);
      rs.d2         = 8'($urandom);
      rs.imm        = 8'($urandom);
      rs.regWrite   = 1'($urandom);
      rs.memRead    = ($urandom_range(0, 2) == 0);
      rs.memWrite   = 1'($urandom);
      rs.aluSrc     = 1'($urandom);
      rs.aluOp      = 3'($urandom);
      rs.flush      = ($urandom_range(0, 5) == 0);
      rs.memBusy    = ($urandom_range(0, 4) == 0);
      rs.wbRegWrite = 1'($urandom);
      rs.wbRd       = 3'($urandom_range(0, 3));
      rs.wbData     = 8'($urandom);
      @(negedge clock);
      applyStim(rs);
      #1;
      check("rndStall", i, 64'(bus.stallIfId), 64'(modelStall(mdl, rs)));
      @(posedge clock);
      #1;
      mdl = modelNext(mdl, rs);
      check("rndEx", i, 64'(readEx()), 64'(mdl));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
